// File: rtl/sha256_pkg.sv
// Shared encodings for the SHA-256 host: command ops, FSM states, word indices and round constants.
package sha256_pkg;

    typedef enum logic [1:0] {
        OP_ROUND      = 2'd0,
        OP_WRITE_WORD = 2'd1,
        OP_READ_WORD  = 2'd2,
        OP_CLR_RND    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        STEP    = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_e;

    localparam logic [3:0] IDX_W = 4'd1;
    localparam logic [3:0] IDX_K = 4'd2;
    localparam logic [3:0] IDX_A = 4'd8;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Only W, K and the working registers A..H exist in the core map.
    function automatic logic idx_valid(input logic [3:0] idx);
        return (idx == IDX_W) || (idx == IDX_K) || (idx >= IDX_A);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant lookup: 6-bit round index to 32-bit K, purely combinational.
// Present only in builds with SHA256_HOST_AUTOK_EN.
`ifdef SHA256_HOST_AUTOK_EN
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [31:0] k_o
);

    assign k_o = K_TABLE[idx_i];

endmodule
`endif

// File: rtl/sha256_host.sv
// Command-to-byte-bus bridge for a SHA-256 round core; one strobe per byte, done/rsp after the last byte.
// Stalls (strobe suppressed, pointer held) while core_ready is low; SHA256_HOST_AUTOK_EN sources K from an internal table.
module sha256_host
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_idx,
    input  logic [31:0] cmd_w,
    input  logic [31:0] cmd_k,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        done,
    output logic [5:0]  bus_addr,
    output logic        bus_dir,
    output logic        bus_strb,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        core_ready
);

    state_e      state_q;
    logic        armed_q;
    logic        pend_q;
    logic        dir_q;
    logic [5:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [2:0]  ptr_q;
    logic [2:0]  last_q;
    logic [63:0] data_q;
    logic        cap_q;
    logic [1:0]  cap_ptr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        done_q;
    logic [31:0] k_sel;
    logic        accept;
    logic        fire;

`ifdef SHA256_HOST_AUTOK_EN
    logic [5:0]  rnd_q;
    logic [31:0] rom_k;
    logic        unused_k;

    sha256_k_rom u_k_rom (
        .idx_i (rnd_q),
        .k_o   (rom_k)
    );

    assign k_sel    = rom_k;
    assign unused_k = ^cmd_k;
`else
    assign k_sel = cmd_k;
`endif

    assign accept = cmd_valid && cmd_ready;
    // A pending strobe only reaches the bus in a cycle where the core can take it.
    assign fire   = pend_q && core_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            pend_q      <= 1'b0;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            last_q      <= '0;
            data_q      <= '0;
            cap_q       <= 1'b0;
            cap_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef SHA256_HOST_AUTOK_EN
            rnd_q       <= '0;
`endif
        end else begin
            armed_q   <= 1'b1;
            done_q    <= 1'b0;
            // Core returns read data the cycle after the strobe; land it one edge later.
            cap_q     <= (state_q == READ) && fire;
            cap_ptr_q <= ptr_q[1:0];
            if (cap_q) begin
                rsp_data_q[{cap_ptr_q, 3'b000} +: 8] <= bus_rdata;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ptr_q <= '0;
                        case (op_e'(cmd_op))
                            OP_ROUND: begin
                                data_q  <= {8'd0, k_sel, cmd_w[31:8]};
                                wdata_q <= cmd_w[7:0];
                                addr_q  <= {IDX_W, 2'b00};
                                last_q  <= 3'd7;
                                dir_q   <= 1'b0;
                                pend_q  <= 1'b1;
                                state_q <= WRITE;
                            end
                            OP_WRITE_WORD: begin
                                if (idx_valid(cmd_idx)) begin
                                    data_q  <= {40'd0, cmd_w[31:8]};
                                    wdata_q <= cmd_w[7:0];
                                    addr_q  <= {cmd_idx, 2'b00};
                                    last_q  <= 3'd3;
                                    dir_q   <= 1'b0;
                                    pend_q  <= 1'b1;
                                    state_q <= WRITE;
                                end else begin
                                    done_q <= 1'b1;
                                end
                            end
                            OP_READ_WORD: begin
                                if (idx_valid(cmd_idx)) begin
                                    wdata_q    <= '0;
                                    addr_q     <= {cmd_idx, 2'b00};
                                    last_q     <= 3'd3;
                                    dir_q      <= 1'b1;
                                    pend_q     <= 1'b1;
                                    rsp_data_q <= '0;
                                    rsp_err_q  <= 1'b0;
                                    state_q    <= READ;
                                end else begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= '0;
                                    rsp_err_q   <= 1'b1;
                                    state_q     <= RESP;
                                end
                            end
                            default: begin
                                done_q <= 1'b1;
`ifdef SHA256_HOST_AUTOK_EN
                                rnd_q  <= '0;
`endif
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (fire) begin
                        if (ptr_q == last_q) begin
                            addr_q  <= '0;
                            wdata_q <= '0;
                            // Eight bytes means W and K were loaded for a round: trigger it at addr 0.
                            if (last_q == 3'd7) begin
                                state_q <= STEP;
                            end else begin
                                pend_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            ptr_q   <= ptr_q + 3'd1;
                            addr_q  <= addr_q + 6'd1;
                            wdata_q <= data_q[7:0];
                            data_q  <= data_q >> 8;
                        end
                    end
                end
                STEP: begin
                    if (fire) begin
                        pend_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef SHA256_HOST_AUTOK_EN
                        rnd_q   <= rnd_q + 6'd1;
`endif
                    end
                end
                READ: begin
                    if (fire) begin
                        if (ptr_q == last_q) begin
                            pend_q  <= 1'b0;
                            dir_q   <= 1'b0;
                            addr_q  <= '0;
                            state_q <= CAPTURE;
                        end else begin
                            ptr_q  <= ptr_q + 3'd1;
                            addr_q <= addr_q + 6'd1;
                        end
                    end
                end
                CAPTURE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = armed_q && (state_q == IDLE) && core_ready;
    assign bus_strb  = fire;
    assign bus_addr  = addr_q;
    assign bus_dir   = dir_q;
    assign bus_wdata = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha256_host.sv
// Directed bench for sha256_host with a byte-addressed core model that executes one SHA-256 round on an addr-0 strobe.
module tb_sha256_host;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_idx = 4'd0;
    logic [31:0] cmd_w = 32'd0;
    logic [31:0] cmd_k = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        done;
    logic [5:0]  bus_addr;
    logic        bus_dir;
    logic        bus_strb;
    logic [7:0]  bus_wdata;
    logic [7:0]  core_rdata = 8'd0;
    logic        core_ready = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  mem [64];
    logic [255:0] nx;

    int          strb_cnt;
    int          done_cyc;
    int          rsp_cyc;
    logic        dir_or;
    logic        dir_and;
    logic [31:0] rsp_dat_s;
    logic        rsp_err_s;
    logic [5:0]  s_addr [16];
    logic [7:0]  s_data [16];
    logic        s_dir  [16];
    int          s_cyc  [16];
    logic [31:0] rd_val;

    sha256_host dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_w      (cmd_w),
        .cmd_k      (cmd_k),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .done       (done),
        .bus_addr   (bus_addr),
        .bus_dir    (bus_dir),
        .bus_strb   (bus_strb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (core_rdata),
        .core_ready (core_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rd32(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    function automatic logic [255:0] sha_step(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Core model: W at 4..7, K at 8..11, A..H at 32..63, little-endian bytes.
    always @(posedge clk) begin
        if (bus_strb) begin
            if (bus_dir) begin
                core_rdata <= mem[bus_addr];
            end else if (bus_addr == 6'd0) begin
                nx = sha_step({rd32(32), rd32(36), rd32(40), rd32(44),
                               rd32(48), rd32(52), rd32(56), rd32(60)}, rd32(4), rd32(8));
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 4; j++)
                        mem[32 + 4*i + j] <= nx[224 - 32*i + 8*j +: 8];
            end else begin
                mem[bus_addr] <= bus_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] w, input logic [31:0] k);
        int t;
        t = 0;
        core_ready = 1'b1;
        cmd_op = op;
        cmd_idx = idx;
        cmd_w = w;
        cmd_k = k;
        #1;
        while (!cmd_ready && t < 20) begin
            tick();
            t++;
        end
        if (!cmd_ready) check("cmd_ready timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Observe cycles 1..n after acceptance; core_ready low in cycles [st_from, st_from+st_len).
    task automatic watch(input int n, input int st_from, input int st_len);
        strb_cnt = 0;
        done_cyc = 0;
        rsp_cyc = 0;
        dir_or = 1'b0;
        dir_and = 1'b1;
        for (int c = 1; c <= n; c++) begin
            core_ready = !(c >= st_from && c < st_from + st_len);
            #1;
            if (bus_strb && strb_cnt < 16) begin
                s_addr[strb_cnt] = bus_addr;
                s_data[strb_cnt] = bus_wdata;
                s_dir[strb_cnt]  = bus_dir;
                s_cyc[strb_cnt]  = c;
                dir_or  = dir_or | bus_dir;
                dir_and = dir_and & bus_dir;
                strb_cnt++;
            end
            if (done && done_cyc == 0) done_cyc = c;
            if (rsp_valid && rsp_cyc == 0) begin
                rsp_cyc = c;
                rsp_dat_s = rsp_data;
                rsp_err_s = rsp_err;
            end
            tick();
        end
        core_ready = 1'b1;
    endtask

    task automatic read_word(input logic [3:0] idx, output logic [31:0] d);
        issue(OP_READ_WORD, idx, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        watch(8, 0, 0);
        rsp_ready = 1'b0;
        d = rsp_dat_s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] iv [8];
        iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst bus", 32'({bus_strb, bus_dir, bus_addr, bus_wdata}), 32'd0);
        check("rst rsp", 32'({rsp_valid, rsp_err, done}), 32'd0);
        check("rst rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

        // WRITE_WORD A = IV0
        issue(OP_WRITE_WORD, 4'd8, iv[0], 32'd0);
        watch(8, 0, 0);
        check("wr strobe count", strb_cnt, 4);
        check("wr addrs", 32'({s_addr[3], s_addr[2], s_addr[1], s_addr[0]}), 32'({6'd35, 6'd34, 6'd33, 6'd32}));
        check("wr data", {s_data[3], s_data[2], s_data[1], s_data[0]}, 32'h6a09e667);
        check("wr dir", 32'(dir_or), 32'd0);
        check("wr first strobe cycle", s_cyc[0], 1);
        check("wr last strobe cycle", s_cyc[3], 4);
        check("wr done cycle", done_cyc, 5);
        check("idle bus", 32'({bus_strb, bus_dir, bus_addr, bus_wdata}), 32'd0);

        for (int i = 1; i < 8; i++) begin
            issue(OP_WRITE_WORD, 4'(8 + i), iv[i], 32'd0);
            watch(8, 0, 0);
            check("iv write done cycle", done_cyc, 5);
        end

        // READ_WORD H with rsp_ready low for three cycles
        issue(OP_READ_WORD, 4'd15, 32'd0, 32'd0);
        rsp_ready = 1'b0;
        watch(6, 0, 0);
        check("rd strobe count", strb_cnt, 4);
        check("rd dir", 32'(dir_and), 32'd1);
        check("rd addrs", 32'({s_addr[3], s_addr[2], s_addr[1], s_addr[0]}), 32'({6'd63, 6'd62, 6'd61, 6'd60}));
        check("rd rsp cycle", rsp_cyc, 6);
        check("rd rsp data", rsp_dat_s, 32'h5be0cd19);
        check("rd rsp err", 32'(rsp_err_s), 32'd0);
        for (int c = 0; c < 2; c++) begin
            check("rd hold valid", 32'(rsp_valid), 32'd1);
            check("rd hold data", rsp_data, 32'h5be0cd19);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd released", 32'(rsp_valid), 32'd0);

        // READ_WORD invalid index
        issue(OP_READ_WORD, 4'd3, 32'd0, 32'd0);
        watch(3, 0, 0);
        check("bad rd strobes", strb_cnt, 0);
        check("bad rd rsp cycle", rsp_cyc, 1);
        check("bad rd data/err", {rsp_dat_s[30:0], rsp_err_s}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // WRITE_WORD invalid index
        issue(OP_WRITE_WORD, 4'd0, 32'hffffffff, 32'd0);
        watch(4, 0, 0);
        check("bad wr strobes", strb_cnt, 0);
        check("bad wr done cycle", done_cyc, 1);

        // WRITE_WORD with core_ready low for 2 cycles after the 2nd strobe
        issue(OP_WRITE_WORD, 4'd2, 32'h11223344, 32'd0);
        watch(10, 3, 2);
        check("stall strobe count", strb_cnt, 4);
        check("stall data", {s_data[3], s_data[2], s_data[1], s_data[0]}, 32'h11223344);
        check("stall addrs", 32'({s_addr[3], s_addr[2], s_addr[1], s_addr[0]}), 32'({6'd11, 6'd10, 6'd9, 6'd8}));
        check("stall 3rd strobe cycle", s_cyc[2], 5);
        check("stall 4th strobe cycle", s_cyc[3], 6);
        check("stall done cycle", done_cyc, 7);

        // ROUND 0 of "abc"
        issue(OP_ROUND, 4'd0, 32'h61626380, 32'h428a2f98);
        watch(12, 0, 0);
        check("rnd strobe count", strb_cnt, 9);
        check("rnd w addrs", 32'({s_addr[3], s_addr[2], s_addr[1], s_addr[0]}), 32'({6'd7, 6'd6, 6'd5, 6'd4}));
        check("rnd k addrs", 32'({s_addr[7], s_addr[6], s_addr[5], s_addr[4]}), 32'({6'd11, 6'd10, 6'd9, 6'd8}));
        check("rnd w data", {s_data[3], s_data[2], s_data[1], s_data[0]}, 32'h61626380);
        check("rnd k data", {s_data[7], s_data[6], s_data[5], s_data[4]}, 32'h428a2f98);
        check("rnd step addr/dir", 32'({s_dir[8], s_addr[8]}), 32'd0);
        check("rnd step cycle", s_cyc[8], 9);
        check("rnd done cycle", done_cyc, 10);
        check("rnd idle bus", 32'({bus_strb, bus_dir, bus_addr, bus_wdata}), 32'd0);
        read_word(4'd8, rd_val);
        check("rnd A", rd_val, 32'h5d6aebcd);
        read_word(4'd12, rd_val);
        check("rnd E", rd_val, 32'hfa2a4622);

        // CLR_RND
        issue(OP_CLR_RND, 4'd0, 32'd0, 32'd0);
        watch(3, 0, 0);
        check("clr strobes", strb_cnt, 0);
        check("clr done cycle", done_cyc, 1);

`ifdef SHA256_HOST_AUTOK_EN
        for (int r = 0; r < 65; r++) begin
            issue(OP_ROUND, 4'd0, 32'd0, 32'hdeadbeef);
            watch(12, 0, 0);
            if (r == 0)  check("autok K round 1", {s_data[7], s_data[6], s_data[5], s_data[4]}, 32'h428a2f98);
            if (r == 63) check("autok K round 64", {s_data[7], s_data[6], s_data[5], s_data[4]}, 32'hc67178f2);
            if (r == 64) check("autok K round 65", {s_data[7], s_data[6], s_data[5], s_data[4]}, 32'h428a2f98);
        end
`else
        issue(OP_ROUND, 4'd0, 32'd0, 32'hdeadbeef);
        watch(12, 0, 0);
        check("cmd_k K bytes", {s_data[7], s_data[6], s_data[5], s_data[4]}, 32'hdeadbeef);
`endif

        // Reset in the middle of a ROUND
        issue(OP_ROUND, 4'd0, 32'h01020304, 32'h05060708);
        watch(3, 0, 0);
        check("pre-reset strobes", strb_cnt, 3);
        rst_n = 1'b0;
        #1;
        check("reset kills strobe", 32'(bus_strb), 32'd0);
        watch(5, 0, 0);
        check("no strobes in reset", strb_cnt, 0);
        check("no done in reset", done_cyc, 0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("cmd_ready after mid reset", 32'(cmd_ready), 32'd1);
        issue(OP_WRITE_WORD, 4'd1, 32'hcafef00d, 32'd0);
        watch(8, 0, 0);
        check("post-reset write done", done_cyc, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
